// File: rtl/adc_spi_frame_rx_pkg.sv
// Shared types and constants for the ADC SPI frame receiver.
// Holds the FSM state type, synchroniser depth and counter-width helpers.
package adc_spi_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2
  } rx_state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One extra bit so that counting up to n itself cannot wrap to zero.
  function automatic int ch_cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/adc_spi_frame_rx_if.sv
// Pin-level and frame-output bundle for the ADC SPI frame receiver.
// The master side drives the SPI pins; the slave side returns the committed frame.
interface adc_spi_frame_rx_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 4
);
  logic                           adc_data;
  logic                           adc_clock;
  logic                           adc_cs;
  logic [CHANNELS*DATA_WIDTH-1:0] data;
  logic                           data_valid;
  logic                           frame_error;
  logic                           busy;

  modport master (
    output adc_data, adc_clock, adc_cs,
    input  data, data_valid, frame_error, busy
  );

  modport slave (
    input  adc_data, adc_clock, adc_cs,
    output data, data_valid, frame_error, busy
  );
endinterface

// File: rtl/adc_spi_frame_rx_sync_edge_detect.sv
// Multi-stage synchroniser for one asynchronous pin, plus one extra
// register that turns the synchronised level into rise/fall pulses.
module sync_edge_detect
  import adc_spi_pkg::*;
#(
  parameter int   STAGES    = SYNC_STAGES,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, forming a true shift chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/adc_spi_frame_rx.sv
// SPI slave receiver: captures CHANNELS words of DATA_WIDTH bits per CS window
// and commits the whole frame atomically to o_Data.
module adc_spi_frame_rx
  import adc_spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int CHANNELS    = 4,
  parameter int SAMPLE_EDGE = 0,
  parameter int MSB_FIRST   = 1
) (
  input  logic                           i_Clock,
  input  logic                           reset_n,
  input  logic                           i_ADC_Data,
  input  logic                           i_ADC_Clock,
  input  logic                           i_ADC_CS,
  output logic [CHANNELS*DATA_WIDTH-1:0] o_Data,
  output logic                           o_Data_Valid,
  output logic                           o_Frame_Error,
  output logic                           o_Busy
);

  localparam int BW = cnt_width(DATA_WIDTH);
  localparam int CW = ch_cnt_width(CHANNELS);
  localparam int IW = cnt_width(CHANNELS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] LAST_CH  = CW'(CHANNELS - 1);

  logic sck_rise, sck_fall, sck_level_unused;
  logic cs_rise, cs_fall, cs_level;
  logic data_level, data_rise_unused, data_fall_unused;
  logic sample;

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk(i_Clock), .rst_n(reset_n), .async_i(i_ADC_Clock),
    .level_o(sck_level_unused), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  // CS idles high, so its chain resets high to avoid a false frame start.
  sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(i_Clock), .rst_n(reset_n), .async_i(i_ADC_CS),
    .level_o(cs_level), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_data_sync (
    .clk(i_Clock), .rst_n(reset_n), .async_i(i_ADC_Data),
    .level_o(data_level), .rise_o(data_rise_unused), .fall_o(data_fall_unused)
  );

  assign sample = (SAMPLE_EDGE != 0) ? sck_fall : sck_rise;

  rx_state_t                      state_q, state_d;
  logic [BW-1:0]                  bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]                  ch_cnt_q, ch_cnt_d;
  logic [DATA_WIDTH-1:0]          shift_q, shift_d;
  logic                           word_done_q, word_done_d;
  logic                           overrun_q, overrun_d;
  logic [DATA_WIDTH-1:0]          staging_q [CHANNELS];
  logic [DATA_WIDTH-1:0]          staging_d [CHANNELS];
  logic [CHANNELS*DATA_WIDTH-1:0] data_q, data_d;
  logic                           valid_q, valid_d;
  logic                           error_q, error_d;
  logic                           busy_q;

  always_ff @(posedge i_Clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      ch_cnt_q    <= '0;
      shift_q     <= '0;
      word_done_q <= 1'b0;
      overrun_q   <= 1'b0;
      // NOTE: the staging array is reset explicitly; it is a handful of
      // registers, not a RAM, and must never leak stale words after reset.
      staging_q   <= '{default: '0};
      data_q      <= '0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      ch_cnt_q    <= ch_cnt_d;
      shift_q     <= shift_d;
      word_done_q <= word_done_d;
      overrun_q   <= overrun_d;
      staging_q   <= staging_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
      busy_q      <= ~cs_level;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    ch_cnt_d    = ch_cnt_q;
    shift_d     = shift_q;
    word_done_d = word_done_q;
    overrun_d   = overrun_q;
    staging_d   = staging_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    error_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d     = SHIFT;
          bit_cnt_d   = '0;
          ch_cnt_d    = '0;
          word_done_d = 1'b0;
          overrun_d   = 1'b0;
        end
      end

      SHIFT: begin
        // CS rise beats any coincident SCK edge; the partial frame is dropped.
        if (cs_rise) begin
          state_d     = IDLE;
          error_d     = 1'b1;
          word_done_d = 1'b0;
        end else begin
          if (word_done_q) begin
            word_done_d                 = 1'b0;
            staging_d[ch_cnt_q[IW-1:0]] = shift_q;
            ch_cnt_d                    = ch_cnt_q + CW'(1);
            if (ch_cnt_q == LAST_CH) begin
              for (int c = 0; c < CHANNELS; c++) begin
                data_d[c*DATA_WIDTH +: DATA_WIDTH] = staging_d[c];
              end
              valid_d = 1'b1;
              state_d = FLUSH;
            end
          end
          if (sample) begin
            if (MSB_FIRST != 0) shift_d = {shift_q[DATA_WIDTH-2:0], data_level};
            else                shift_d = {data_level, shift_q[DATA_WIDTH-1:1]};
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d   = '0;
              word_done_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end
        end
      end

      FLUSH: begin
        if (cs_rise) begin
          state_d   = IDLE;
          error_d   = overrun_q;
          overrun_d = 1'b0;
        end else if (sample) begin
          overrun_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign o_Data        = data_q;
  assign o_Data_Valid  = valid_q;
  assign o_Frame_Error = error_q;
  assign o_Busy        = busy_q;

endmodule
